// File: rtl/sensor_porta_giratoria.sv
// Revolving-door sensor front end: synchronizes and debounces the raw
// sensors, then tracks passages and counts entries, exits and lockouts.
module sensor_porta_giratoria #(
    parameter int DEB_CYCLES = 270000,
    parameter int CNT_W      = 8
) (
    input  logic             CLOCK_27,
    input  logic             RESET,
    input  logic [2:0]       SENS_RAW,
    input  logic [1:0]       PORTA_OK,
    input  logic [3:0]       PORTA_STATUS,
    output logic [2:0]       SW_OUT,
    output logic [CNT_W-1:0] ENTRADAS,
    output logic [CNT_W-1:0] SAIDAS,
    output logic [CNT_W-1:0] BLOQ_CNT,
    output logic             OCUPADA
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        ENTRANDO,
        SAINDO,
        BLOQUEADO
    } state_t;

    logic [2:0] s1_q;
    logic [2:0] s2_q;
    logic [2:0] sw_q;

    always_ff @(posedge CLOCK_27 or posedge RESET) begin
        if (RESET) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= SENS_RAW;
            s2_q <= s1_q;
        end
    end

    // The output bit only moves after DEB_CYCLES consecutive disagreements.
    for (genvar b = 0; b < 3; b++) begin : g_deb
        logic [DW-1:0] cnt_q;
        logic          bit_q;

        always_ff @(posedge CLOCK_27 or posedge RESET) begin
            if (RESET) begin
                cnt_q <= '0;
                bit_q <= 1'b0;
            end else if (s2_q[b] == bit_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                cnt_q <= '0;
                bit_q <= s2_q[b];
            end else begin
                cnt_q <= cnt_q + DW'(1);
            end
        end

        assign sw_q[b] = bit_q;
    end

    state_t           st_q;
    state_t           st_d;
    logic             ent_inc;
    logic             sai_inc;
    logic             blq_inc;
    logic             lock;
    logic [CNT_W-1:0] ent_q;
    logic [CNT_W-1:0] sai_q;
    logic [CNT_W-1:0] blq_q;
    logic             ocup_q;

    assign lock = PORTA_STATUS[3];

    always_comb begin
        st_d    = st_q;
        ent_inc = 1'b0;
        sai_inc = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (lock)
                    st_d = BLOQUEADO;
                else if (PORTA_OK[0] && sw_q[2])
                    st_d = ENTRANDO;
                else if (PORTA_OK[1] && sw_q[1])
                    st_d = SAINDO;
            end
            ENTRANDO: begin
                if (lock) begin
                    st_d = BLOQUEADO;
                end else if (!sw_q[2]) begin
                    st_d    = IDLE;
                    ent_inc = 1'b1;
                end
            end
            SAINDO: begin
                if (lock) begin
                    st_d = BLOQUEADO;
                end else if (!sw_q[1]) begin
                    st_d    = IDLE;
                    sai_inc = 1'b1;
                end
            end
            BLOQUEADO: begin
                if (!lock && sw_q == 3'b000)
                    st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    assign blq_inc = (st_d == BLOQUEADO) && (st_q != BLOQUEADO);

    always_ff @(posedge CLOCK_27 or posedge RESET) begin
        if (RESET) begin
            st_q   <= IDLE;
            ocup_q <= 1'b0;
            ent_q  <= '0;
            sai_q  <= '0;
            blq_q  <= '0;
        end else begin
            st_q   <= st_d;
            ocup_q <= (st_d != IDLE);
            if (ent_inc && ent_q != CNT_MAX)
                ent_q <= ent_q + CNT_W'(1);
            if (sai_inc && sai_q != CNT_MAX)
                sai_q <= sai_q + CNT_W'(1);
            if (blq_inc && blq_q != CNT_MAX)
                blq_q <= blq_q + CNT_W'(1);
        end
    end

    assign SW_OUT   = sw_q;
    assign ENTRADAS = ent_q;
    assign SAIDAS   = sai_q;
    assign BLOQ_CNT = blq_q;
    assign OCUPADA  = ocup_q;

endmodule

// File: tb/tb_sensor_porta_giratoria.sv
// Bench for sensor_porta_giratoria: directed phases plus random traffic,
// scoreboarded per cycle against a history-based reference model.
module tb_sensor_porta_giratoria;

    localparam int DEB = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [2:0] raw  = '0;
    logic [1:0] ok   = '0;
    logic [3:0] stat = '0;

    logic [2:0] sw8, sw2;
    logic [7:0] e8, s8, b8;
    logic [1:0] e2, s2, b2;
    logic       oc8, oc2;

    always #5 clk = ~clk;

    sensor_porta_giratoria #(.DEB_CYCLES(DEB), .CNT_W(8)) dut8 (
        .CLOCK_27(clk), .RESET(rst), .SENS_RAW(raw),
        .PORTA_OK(ok), .PORTA_STATUS(stat), .SW_OUT(sw8),
        .ENTRADAS(e8), .SAIDAS(s8), .BLOQ_CNT(b8), .OCUPADA(oc8)
    );

    sensor_porta_giratoria #(.DEB_CYCLES(DEB), .CNT_W(2)) dut2 (
        .CLOCK_27(clk), .RESET(rst), .SENS_RAW(raw),
        .PORTA_OK(ok), .PORTA_STATUS(stat), .SW_OUT(sw2),
        .ENTRADAS(e2), .SAIDAS(s2), .BLOQ_CNT(b2), .OCUPADA(oc2)
    );

    typedef struct {
        logic [2:0] sw;
        int         ent;
        int         sai;
        int         blq;
        logic       ocup;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: true (unbounded) counts, passage mode as an int,
    // and a window of the last DEB synchronized samples per bit.
    logic [2:0] m_sw;
    logic [2:0] m_dly[$];
    logic [2:0] m_hist[$];
    int         m_mode;
    int         m_ent, m_sai, m_blq;

    task automatic m_reset();
        m_sw = '0;
        m_dly.delete();
        m_dly.push_back(3'b000);
        m_dly.push_back(3'b000);
        m_hist.delete();
        for (int i = 0; i < DEB; i++) m_hist.push_back(3'b000);
        m_mode = 0;
        m_ent  = 0;
        m_sai  = 0;
        m_blq  = 0;
    endtask

    task automatic m_step();
        logic [2:0] v;
        logic       lk;
        logic       flip;
        lk = stat[3];
        v  = m_dly.pop_front();
        m_dly.push_back(raw);
        case (m_mode)
            0: begin
                if (lk) begin m_mode = 3; m_blq++; end
                else if (ok[0] && m_sw[2]) m_mode = 1;
                else if (ok[1] && m_sw[1]) m_mode = 2;
            end
            1: begin
                if (lk) begin m_mode = 3; m_blq++; end
                else if (!m_sw[2]) begin m_mode = 0; m_ent++; end
            end
            2: begin
                if (lk) begin m_mode = 3; m_blq++; end
                else if (!m_sw[1]) begin m_mode = 0; m_sai++; end
            end
            default: begin
                if (!lk && m_sw == 3'b000) m_mode = 0;
            end
        endcase
        m_hist.push_back(v);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            foreach (m_hist[k])
                if (m_hist[k][b] == m_sw[b]) flip = 1'b0;
            if (flip) m_sw[b] = ~m_sw[b];
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (rst) m_reset();
        else     m_step();
        e.sw   = m_sw;
        e.ent  = m_ent;
        e.sai  = m_sai;
        e.blq  = m_blq;
        e.ocup = (m_mode != 0);
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = sbq.pop_front();
            if (rst) begin
                e.sw = '0; e.ent = 0; e.sai = 0; e.blq = 0; e.ocup = 1'b0;
            end
            chk("sw8",  int'(sw8), int'(e.sw));
            chk("sw2",  int'(sw2), int'(e.sw));
            chk("ent8", int'(e8),  sat(e.ent, 255));
            chk("sai8", int'(s8),  sat(e.sai, 255));
            chk("blq8", int'(b8),  sat(e.blq, 255));
            chk("ent2", int'(e2),  sat(e.ent, 3));
            chk("sai2", int'(s2),  sat(e.sai, 3));
            chk("blq2", int'(b2),  sat(e.blq, 3));
            chk("ocup8", int'(oc8), int'(e.ocup));
            chk("ocup2", int'(oc2), int'(e.ocup));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);

        // bounce on the entry sensor, then a clean rise
        for (int i = 0; i < 5; i++) begin
            raw[2] = 1'b1; tick(2);
            raw[2] = 1'b0; tick(2);
        end
        raw[2] = 1'b1;
        tick(5);
        chk("bounce_pre", int'(sw8[2]), 0);
        tick(1);
        chk("bounce_edge", int'(sw8[2]), 1);
        tick(4);
        raw = 3'b000;
        tick(12);

        // clean entry
        ok = 2'b01;
        raw = 3'b100; tick(12);
        raw = 3'b000; tick(12);
        chk("entry_cnt", int'(e8), 1);

        // lock during entry
        raw = 3'b100; tick(8);
        stat = 4'hF; tick(3);
        chk("lock_blq", int'(b8), 1);
        chk("lock_ent", int'(e8), 1);
        stat = 4'h0; raw = 3'b000; tick(12);
        chk("lock_idle", int'(oc8), 0);

        // exit completion and lock on the same edge
        ok = 2'b10;
        raw = 3'b010; tick(12);
        raw = 3'b000; tick(6);
        stat = 4'b1000; tick(3);
        chk("simul_blq", int'(b8), 2);
        chk("simul_sai", int'(s8), 0);
        stat = 4'h0; tick(8);

        // asynchronous reset mid-run
        ok = 2'b00;
        raw = 3'b111; tick(10);
        rst = 1'b1;
        #1;
        chk("rst_sw",  int'(sw8), 0);
        chk("rst_ent", int'(e8),  0);
        chk("rst_blq", int'(b8),  0);
        chk("rst_oc",  int'(oc8), 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("rel_pre", int'(sw8), 0);
        tick(1);
        chk("rel_edge", int'(sw8), 7);
        raw = 3'b000; tick(10);

        // saturation of the 2-bit exit counter
        rst = 1'b1; tick(2);
        rst = 1'b0; tick(2);
        ok = 2'b10;
        for (int i = 0; i < 5; i++) begin
            raw = 3'b010; tick(10);
            raw = 3'b000; tick(10);
            chk($sformatf("sat2_exit%0d", i), int'(s2), sat(i + 1, 3));
            chk($sformatf("sat8_exit%0d", i), int'(s8), i + 1);
        end

        // random traffic
        repeat (300) begin
            raw = 3'($urandom);
            ok  = 2'($urandom);
            if ($urandom_range(0, 7) == 0)
                stat = 4'($urandom) | 4'b1000;
            else
                stat = 4'($urandom) & 4'b0111;
            tick($urandom_range(1, 8));
        end

        raw = '0; ok = '0; stat = '0;
        tick(20);
        #6;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_porta_giratoria.md
Name: sensor_porta_giratoria

Overview:
Sensor-side front end for the revolving-door controller. It conditions the raw door sensors into the clean 3-bit sensor vector the controller consumes. It also reads back the controller's status lights and tracks each passage through the door, counting completed entries, completed exits and lockout events. It sits between the board inputs and the door controller, and drives the controller's sensor input.

Parameters:
DEB_CYCLES, 270000, consecutive stable cycles required before a debounced bit changes (10 ms at 27 MHz; benches use 4)
CNT_W, 8, width of each event counter

Ports:
CLOCK_27  input  1  system clock
RESET  input  1  asynchronous, active-high reset
SENS_RAW  input  3  raw sensors, asynchronous and bouncing: [0] metal, [1] person exiting, [2] person entering
PORTA_OK  input  2  controller green status: [1] may exit, [0] may enter
PORTA_STATUS  input  4  controller red status: [3] door locked, [2] alarm, [1] cannot exit, [0] cannot enter
SW_OUT  output  3  debounced sensor vector to the controller, same bit mapping as SENS_RAW
ENTRADAS  output  CNT_W  completed entries, saturating
SAIDAS  output  CNT_W  completed exits, saturating
BLOQ_CNT  output  CNT_W  lockout events, saturating
OCUPADA  output  1  high while a passage is in progress or the door is locked

Behaviour:
- Reset is asynchronous. While RESET=1: SW_OUT=000, all counters 0, OCUPADA=0, synchronizers and debounce counters cleared, FSM in IDLE. Asserting RESET mid-passage aborts the passage with no count.
- Synchronizer: each SENS_RAW bit passes through 2 flops.
- Debounce, independently per bit:
  - A counter runs while the synchronized value differs from the SW_OUT bit.
  - The counter clears on any cycle where the two agree.
  - The SW_OUT bit flips when the counter reaches DEB_CYCLES-1.
  - Clean-edge latency from SENS_RAW to SW_OUT is exactly DEB_CYCLES+2 cycles.
  - A pulse shorter than DEB_CYCLES cycles (after sync) never reaches SW_OUT.
- SW_OUT is registered and glitch-free.
- Passage FSM (states IDLE, ENTRANDO, SAINDO, BLOQUEADO), evaluated on current SW_OUT / PORTA_OK / PORTA_STATUS at each rising edge:
  - IDLE:
    - PORTA_OK[0]=1 and SW_OUT[2]=1 -> ENTRANDO.
    - else PORTA_OK[1]=1 and SW_OUT[1]=1 -> SAINDO.
    - Entry has priority if both PORTA_OK bits are set.
    - PORTA_STATUS[3]=1 in IDLE -> BLOQUEADO.
  - ENTRANDO:
    - PORTA_STATUS[3]=1 -> BLOQUEADO.
    - else SW_OUT[2]=0 -> IDLE and ENTRADAS+1.
    - else stay.
  - SAINDO:
    - PORTA_STATUS[3]=1 -> BLOQUEADO.
    - else SW_OUT[1]=0 -> IDLE and SAIDAS+1.
    - else stay.
  - BLOQUEADO: PORTA_STATUS[3]=0 and SW_OUT=000 -> IDLE, with no count.
  - Lock has priority over completion when both occur in the same cycle.
- BLOQ_CNT increments by 1 on every transition into BLOQUEADO, from any state.
- Counters update on the same edge as the FSM transition, then hold at 2^CNT_W-1 (no wrap).
- OCUPADA = 1 in ENTRANDO, SAINDO or BLOQUEADO; registered, tracking the state.
- Controller status inputs are synchronous to CLOCK_27 and used without synchronization.

Test Plan:
- Reset: DEB_CYCLES=4, CNT_W=8, assert RESET mid-simulation with SENS_RAW=111 -> SW_OUT=000, all counters 0 and OCUPADA=0 immediately (asynchronous); after release SW_OUT=111 exactly 6 cycles later.
- Bounce: SENS_RAW[2] toggles every 2 cycles for 20 cycles, then holds 1 -> SW_OUT[2] stays 0 throughout the toggling and rises exactly 6 cycles after the final edge.
- Clean entry: PORTA_OK=01, SENS_RAW=100 for 12 cycles, then 000 -> OCUPADA rises 1 cycle after SW_OUT[2]; ENTRADAS goes 0->1 one cycle after SW_OUT[2] falls; SAIDAS and BLOQ_CNT stay 0.
- Metal during entry: enter ENTRANDO, then PORTA_STATUS=1111 -> BLOQ_CNT=1, ENTRADAS unchanged; set PORTA_STATUS=0000 and SENS_RAW=000 -> FSM returns to IDLE, OCUPADA=0, no count.
- Saturation: CNT_W=2, PORTA_OK=10, perform 5 clean exits -> SAIDAS reads 1,2,3,3,3.
- Simultaneous: in SAINDO, SW_OUT[1] falls on the same cycle PORTA_STATUS[3] rises -> BLOQUEADO entered, BLOQ_CNT+1, SAIDAS unchanged.
